// File: rtl/bitstream_packer_pkg.sv
// -----------------------------------------------------------------------------
// bitstream_packer_pkg
// Shared encoder-side definitions for the variable-length codeword path:
//   - VLC_MAX_LEN : longest codeword (16-bit Huffman code + 11 magnitude bits)
//   - packer FSM state encodings (legacy localparams plus a typed enum twin)
//   - VLC_PACKET  : {code, len} handed from the Huffman/magnitude merge stage
//   - clamp_len   : saturates a codeword length to a legal maximum
// The output bus width comes from the project-wide `IN_BUS_WIDTH macro.
// -----------------------------------------------------------------------------
`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif

package bitstream_packer_pkg;

   localparam int VLC_MAX_LEN = 27;
   localparam int VLC_LEN_W   = 5;

   // Packer FSM encodings
   localparam logic [1:0] PK_ST_IDLE  = 2'd0;
   localparam logic [1:0] PK_ST_RUN   = 2'd1;
   localparam logic [1:0] PK_ST_FLUSH = 2'd2;
   localparam logic [1:0] PK_ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      PK_IDLE  = PK_ST_IDLE,
      PK_RUN   = PK_ST_RUN,
      PK_FLUSH = PK_ST_FLUSH,
      PK_DONE  = PK_ST_DONE
   } pk_state_e;

   // Codeword as produced by the upstream Huffman/magnitude merge
   typedef struct packed {
      logic [VLC_MAX_LEN-1:0] code;
      logic [VLC_LEN_W-1:0]   len;
   } VLC_PACKET;

   // Saturate an incoming length so an illegal value cannot overrun the
   // accumulator.
   function automatic logic [VLC_LEN_W-1:0] clamp_len(
      input logic [VLC_LEN_W-1:0] len,
      input logic [VLC_LEN_W-1:0] max_len
   );
      logic [VLC_LEN_W-1:0] res;
      if (len > max_len) begin
         res = max_len;
      end else begin
         res = len;
      end
      return res;
   endfunction

endpackage

// File: rtl/bitstream_packer_chk.sv
// -----------------------------------------------------------------------------
// bitstream_packer_chk
// Protocol checker for bitstream_packer. Flags any accepted codeword whose
// length exceeds MAX_LEN (the datapath clamps such lengths).
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   valid_in, ready_out codeword handshake
//   len_in             codeword length
// -----------------------------------------------------------------------------
module bitstream_packer_chk #(
   parameter int MAX_LEN = 27
) (
   input logic       clk,
   input logic       rst,
   input logic       valid_in,
   input logic       ready_out,
   input logic [4:0] len_in
);

   localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

   // Accepted codewords must have a legal length
   a_len_legal: assert property (@(posedge clk) disable iff (!rst)
      (valid_in && ready_out) |-> (len_in <= MAX_LEN_L));

endmodule

// File: rtl/bitstream_packer.sv
// -----------------------------------------------------------------------------
// bitstream_packer
// Packs LSB-first variable-length codewords into BUS_W-bit words for the
// decoder front end, under the decoder's request flow control. An end-of-scan
// flush pads the last partial word with 1s and then pulses done_out.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   code_in    codeword, LSB is the first stream bit; bits >= len_in ignored
//   len_in     codeword length 0..MAX_LEN (0 = no-op)
//   valid_in   codeword valid
//   ready_out  codeword accepted when valid_in && ready_out
//   flush_in   end-of-scan, sampled when ready_out = 1
//   data_out   packed word (0 when valid_out = 0)
//   valid_out  data_out valid
//   request    downstream takes a word when valid_out && request
//   done_out   one-cycle pulse when the flush has completed
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module bitstream_packer
   import bitstream_packer_pkg::*;
#(
   parameter int BUS_W   = `IN_BUS_WIDTH,
   parameter int MAX_LEN = VLC_MAX_LEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [MAX_LEN-1:0] code_in,
   input  logic [4:0]         len_in,
   input  logic               valid_in,
   output logic               ready_out,
   input  logic               flush_in,
   output logic [BUS_W-1:0]   data_out,
   output logic               valid_out,
   input  logic               request,
   output logic               done_out
);

   localparam int ACC_W = BUS_W + MAX_LEN;
   localparam int CNT_W = $clog2(ACC_W + 1);

   localparam logic [CNT_W-1:0] BUS_CNT   = CNT_W'(BUS_W);
   localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
   localparam logic [4:0]       MAX_LEN_L = 5'(MAX_LEN);
   localparam logic [ACC_W-1:0] WORD_MASK = {{MAX_LEN{1'b0}}, {BUS_W{1'b1}}};

   logic [ACC_W-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       state_r;

   logic [ACC_W-1:0] acc_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [1:0]       state_nxt_s;

   logic             run_s;
   logic             flush_st_s;
   logic             ready_s;
   logic             valid_s;
   logic             accept_s;
   logic             xfer_s;
   logic [4:0]       len_eff_s;
   logic [CNT_W-1:0] len_cnt_s;
   logic [ACC_W-1:0] code_ext_s;
   logic [ACC_W-1:0] acc_shift_s;
   logic [CNT_W-1:0] base_s;
   logic [ACC_W-1:0] fill_s;

   assign run_s      = (state_r == PK_ST_RUN);
   assign flush_st_s = (state_r == PK_ST_FLUSH);
   assign ready_s    = run_s && (cnt_r <= BUS_CNT);
   assign valid_s    = (run_s || flush_st_s) && (cnt_r >= BUS_CNT);
   assign accept_s   = valid_in && ready_s;
   assign xfer_s     = valid_s && request;

   // Illegal lengths are saturated so the accumulator can never overflow
   assign len_eff_s  = clamp_len(len_in, MAX_LEN_L);
   assign len_cnt_s  = {{(CNT_W-5){1'b0}}, len_eff_s};
   assign code_ext_s = {{BUS_W{1'b0}}, code_in} & ~({ACC_W{1'b1}} << len_eff_s);

   // When a word leaves in the same cycle, the new code lands in the
   // already-shifted accumulator at cnt - BUS_W. Bits above cnt are always
   // zero, so OR-ing the code in is sufficient.
   assign acc_shift_s = xfer_s ? (acc_r >> BUS_W) : acc_r;
   assign base_s      = xfer_s ? (cnt_r - BUS_CNT) : cnt_r;

   // 1s from the current fill level up to the end of the output word
   assign fill_s = ({ACC_W{1'b1}} << cnt_r) & WORD_MASK;

   // Next-state, accumulator and fill-count update
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         PK_ST_IDLE: begin
            state_nxt_s = PK_ST_RUN;
         end
         PK_ST_RUN: begin
            if (accept_s) begin
               acc_nxt_s = acc_shift_s | (code_ext_s << base_s);
               cnt_nxt_s = base_s + len_cnt_s;
            end else begin
               acc_nxt_s = acc_shift_s;
               cnt_nxt_s = base_s;
            end
            // A code offered with the flush is accepted above first
            if (ready_s && flush_in) begin
               state_nxt_s = PK_ST_FLUSH;
            end else begin
               state_nxt_s = PK_ST_RUN;
            end
         end
         PK_ST_FLUSH: begin
            if (xfer_s) begin
               acc_nxt_s = acc_shift_s;
               cnt_nxt_s = base_s;
            end else if (cnt_r == ZERO_CNT) begin
               state_nxt_s = PK_ST_DONE;
            end else if (cnt_r < BUS_CNT) begin
               acc_nxt_s = acc_r | fill_s;
               cnt_nxt_s = BUS_CNT;
            end else begin
               // Full word waiting for request
               acc_nxt_s = acc_r;
            end
         end
         PK_ST_DONE: begin
            acc_nxt_s   = {ACC_W{1'b0}};
            cnt_nxt_s   = ZERO_CNT;
            state_nxt_s = PK_ST_RUN;
         end
         default: begin
            acc_nxt_s   = {ACC_W{1'b0}};
            cnt_nxt_s   = ZERO_CNT;
            state_nxt_s = PK_ST_IDLE;
         end
      endcase
   end

   // State registers, cleared asynchronously so buffered bits are discarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r   <= {ACC_W{1'b0}};
         cnt_r   <= ZERO_CNT;
         state_r <= PK_ST_IDLE;
      end else begin
         acc_r   <= acc_nxt_s;
         cnt_r   <= cnt_nxt_s;
         state_r <= state_nxt_s;
      end
   end

   assign ready_out = ready_s;
   assign valid_out = valid_s;
   assign data_out  = valid_s ? acc_r[BUS_W-1:0] : {BUS_W{1'b0}};
   assign done_out  = (state_r == PK_ST_DONE);

   bitstream_packer_chk #(
      .MAX_LEN (MAX_LEN)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .len_in    (len_in)
   );

endmodule

// File: tb/tb_bitstream_packer.sv
// -----------------------------------------------------------------------------
// tb_bitstream_packer
// Scoreboard bench: each scenario pushes the words it expects, a monitor pops
// and compares every word actually taken by the downstream (valid && request).
// Scenario tasks additionally check handshake/status outputs inline.
// -----------------------------------------------------------------------------
module tb_bitstream_packer;

   logic        clk;
   logic        rst;
   logic [26:0] code_in;
   logic [4:0]  len_in;
   logic        valid_in;
   logic        ready_out;
   logic        flush_in;
   logic [31:0] data_out;
   logic        valid_out;
   logic        request;
   logic        done_out;

   logic [31:0] exp_q[$];
   int          vectors;
   int          miscompares;

   bitstream_packer #(
      .BUS_W   (32),
      .MAX_LEN (27)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .code_in   (code_in),
      .len_in    (len_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .flush_in  (flush_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .request   (request),
      .done_out  (done_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: just before each rising edge, a word with valid && request leaves
   initial begin
      logic [31:0] w;
      forever begin
         @(negedge clk);
         #4;
         if (rst && valid_out && request) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL word_xfer: got unexpected word %h, none expected", data_out);
            end else begin
               w = exp_q.pop_front();
               if (data_out !== w) begin
                  miscompares++;
                  $display("FAIL word_xfer: got %h expected %h", data_out, w);
               end
            end
         end
      end
   end

   // Offer one codeword starting at a falling edge; returns at the falling
   // edge following the rising edge that accepted it.
   task automatic send_code(input logic [26:0] c, input logic [4:0] l, input logic fl);
      int   guard;
      logic took;
      guard    = 0;
      took     = 1'b0;
      code_in  = c;
      len_in   = l;
      valid_in = 1'b1;
      flush_in = fl;
      while (!took && guard < 50) begin
         took = ready_out;
         @(negedge clk);
         guard++;
      end
      valid_in = 1'b0;
      flush_in = 1'b0;
      code_in  = 27'd0;
      len_in   = 5'd0;
      if (!took) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: ready_out %b never seen, required 1", ready_out);
      end
   endtask

   // Flush carrying a final code, then require exactly one done pulse after
   // every expected word has been taken, and ready_out back afterwards.
   task automatic flush_and_wait(input logic [26:0] c, input logic [4:0] l);
      int pulses;
      int q_at_done;
      pulses    = 0;
      q_at_done = -1;
      send_code(c, l, 1'b1);
      for (int i = 0; i < 12; i++) begin
         if (done_out === 1'b1) begin
            pulses++;
            q_at_done = exp_q.size();
         end
         @(negedge clk);
      end
      vectors++;
      if (pulses !== 1) begin
         miscompares++;
         $display("FAIL done_pulse_count: got %0d expected 1", pulses);
      end
      vectors++;
      if (q_at_done !== 0) begin
         miscompares++;
         $display("FAIL done_after_words: words pending at done %0d expected 0", q_at_done);
      end
      vectors++;
      if (ready_out !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_done: got %b expected 1", ready_out);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({ready_out, valid_out, done_out} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: ready/valid/done %b expected 000", {ready_out, valid_out, done_out});
      end
      vectors++;
      if (data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 00000000", data_out);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({ready_out, valid_out} !== 2'b10) begin
         miscompares++;
         $display("FAIL run_entry: ready/valid %b expected 10", {ready_out, valid_out});
      end
   endtask

   task automatic test_pack_bytes();
      logic [7:0] b[4];
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
      request = 1'b1;
      exp_q.push_back(32'h44332211);
      for (int i = 0; i < 4; i++) begin
         send_code({19'd0, b[i]}, 5'd8, 1'b0);
      end
      vectors++;
      if (valid_out !== 1'b1 || data_out !== 32'h44332211) begin
         miscompares++;
         $display("FAIL pack_word_latency: valid %b data %h expected 1 44332211", valid_out, data_out);
      end
      @(negedge clk);
      vectors++;
      if ({ready_out, valid_out} !== 2'b10) begin
         miscompares++;
         $display("FAIL pack_drained: ready/valid %b expected 10", {ready_out, valid_out});
      end
   endtask

   task automatic test_flush_pad();
      request = 1'b1;
      exp_q.push_back(32'h345ABCDE);
      exp_q.push_back(32'hFFFFFF12);
      send_code(27'h00ABCDE, 5'd20, 1'b0);
      flush_and_wait(27'h0012345, 5'd20);
   endtask

   task automatic test_backpressure();
      request = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         send_code(27'(i), 5'd8, 1'b0);
      end
      send_code(27'h55, 5'd8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({ready_out, valid_out} !== 2'b01 || data_out !== 32'h04030201) begin
            miscompares++;
            $display("FAIL backpressure_hold: ready/valid %b data %h expected 01 04030201",
                     {ready_out, valid_out}, data_out);
         end
         @(negedge clk);
      end
      exp_q.push_back(32'h04030201);
      request = 1'b1;
      @(negedge clk);
      vectors++;
      if ({ready_out, valid_out} !== 2'b10) begin
         miscompares++;
         $display("FAIL backpressure_release: ready/valid %b expected 10", {ready_out, valid_out});
      end
      exp_q.push_back(32'hFFFFFF55);
      flush_and_wait(27'd0, 5'd0);
   endtask

   task automatic test_back_to_back();
      request = 1'b0;
      send_code(27'h10, 5'd8, 1'b0);
      send_code(27'h20, 5'd8, 1'b0);
      send_code(27'h30, 5'd8, 1'b0);
      send_code(27'h40, 5'd8, 1'b0);
      exp_q.push_back(32'h40302010);
      request = 1'b1;
      send_code(27'h5A5A5A5, 5'd27, 1'b0);
      vectors++;
      if ({ready_out, valid_out} !== 2'b10) begin
         miscompares++;
         $display("FAIL simultaneous_state: ready/valid %b expected 10", {ready_out, valid_out});
      end
      exp_q.push_back(32'hFDA5A5A5);
      flush_and_wait(27'd0, 5'd0);
   endtask

   task automatic test_flush_empty();
      int valid_seen;
      valid_seen = 0;
      request = 1'b1;
      send_code(27'd0, 5'd0, 1'b1);
      vectors++;
      if (done_out !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_done_early: got %b expected 0", done_out);
      end
      valid_seen += int'(valid_out);
      @(negedge clk);
      vectors++;
      if (done_out !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_done_pulse: got %b expected 1", done_out);
      end
      valid_seen += int'(valid_out);
      @(negedge clk);
      vectors++;
      if ({done_out, ready_out} !== 2'b01) begin
         miscompares++;
         $display("FAIL empty_done_end: done/ready %b expected 01", {done_out, ready_out});
      end
      vectors++;
      if (valid_seen !== 0) begin
         miscompares++;
         $display("FAIL empty_no_word: valid cycles %0d expected 0", valid_seen);
      end
   endtask

   task automatic test_reset_midop();
      request = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send_code(27'(i), 5'd8, 1'b0);
      end
      vectors++;
      if ({ready_out, valid_out} !== 2'b01) begin
         miscompares++;
         $display("FAIL pre_reset_fill: ready/valid %b expected 01", {ready_out, valid_out});
      end
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if ({ready_out, valid_out, done_out} !== 3'b000 || data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset: ready/valid/done %b data %h expected 000 00000000",
                  {ready_out, valid_out, done_out}, data_out);
      end
      @(negedge clk);
      rst = 1'b1;
      request = 1'b1;
      exp_q.push_back(32'hAAAAAAAA);
      for (int i = 0; i < 4; i++) begin
         send_code(27'hAA, 5'd8, 1'b0);
      end
      vectors++;
      if (valid_out !== 1'b1 || data_out !== 32'hAAAAAAAA) begin
         miscompares++;
         $display("FAIL post_reset_word: valid %b data %h expected 1 AAAAAAAA", valid_out, data_out);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      code_in     = 27'd0;
      len_in      = 5'd0;
      valid_in    = 1'b0;
      flush_in    = 1'b0;
      request     = 1'b0;

      test_reset();
      test_pack_bytes();
      test_flush_pad();
      test_backpressure();
      test_back_to_back();
      test_flush_empty();
      test_reset_midop();

      repeat (3) @(negedge clk);
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL words_missing: %0d expected words never taken, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
